// File: rtl/ifetch_prefetch_ctrl_pkg.sv
// Shared types and constants for the instruction prefetch sequencer.
// A FIFO entry is {pc, instr}: the PC sits in the high field and the instruction in the low field.
package ifetch_prefetch_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      WAIT  = 2'd2,
      DRAIN = 2'd3
   } ipf_state_e;

   localparam int unsigned PC_INC = 4;

endpackage

// File: rtl/ipf_credit_cnt.sv
// FIFO occupancy, outstanding-request and discard counters for the prefetcher.
// Also produces the issue credit, both for this cycle and as it will be next cycle.
module ipf_credit_cnt
   import ifetch_prefetch_ctrl_pkg::*;
#(
   parameter int DEPTH_LOG2 = 3,
   parameter int MAX_OUTST  = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic gnt_fire,
   input  logic rvalid,
   input  logic pop,
   input  logic redirect,
   input  logic held,
   input  logic flush,
   output logic push,
   output logic credit,
   output logic credit_nxt,
   output logic drained
);

   localparam logic [DEPTH_LOG2+1:0] CAP     = {2'b01, {DEPTH_LOG2{1'b0}}};
   localparam logic [DEPTH_LOG2:0]   OCC_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};
   localparam logic [1:0]            MAXO    = MAX_OUTST[1:0];

   logic [DEPTH_LOG2:0] occ, occ_nxt;
   logic [1:0]          outst, outst_nxt, discard, discard_nxt;
   logic                rsp_ok, pop_ok;

   function automatic logic credit_of(logic [DEPTH_LOG2:0] o, logic [1:0] t);
      logic [DEPTH_LOG2+1:0] sum;
      sum = {1'b0, o} + {{DEPTH_LOG2{1'b0}}, t};
      return (sum < CAP) && (t < MAXO);
   endfunction

   // A response with nothing outstanding is a bus error; never let it push or underflow.
   assign rsp_ok = rvalid && (outst != 2'd0);
   assign push   = rsp_ok && (discard == 2'd0) && !redirect;
   // Pops while the FIFO is being cleared refer to entries that are already gone.
   assign pop_ok = pop && !redirect && !flush && (occ != '0);

   always_comb begin
      outst_nxt = outst;
      if (gnt_fire) outst_nxt = outst_nxt + 2'd1;
      if (rsp_ok)   outst_nxt = outst_nxt - 2'd1;

      occ_nxt = occ;
      if (redirect) begin
         occ_nxt = '0;
      end else begin
         if (push)   occ_nxt = occ_nxt + OCC_ONE;
         if (pop_ok) occ_nxt = occ_nxt - OCC_ONE;
      end

      discard_nxt = discard;
      if (redirect)
         discard_nxt = outst_nxt + {1'b0, held};
      else if (rsp_ok && (discard != 2'd0))
         discard_nxt = discard - 2'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         occ     <= '0;
         outst   <= '0;
         discard <= '0;
      end else begin
         occ     <= occ_nxt;
         outst   <= outst_nxt;
         discard <= discard_nxt;
      end
   end

   assign credit     = credit_of(occ, outst);
   assign credit_nxt = credit_of(occ_nxt, outst_nxt);
   assign drained    = (discard == 2'd0) && (outst == 2'd0);

endmodule

// File: rtl/ifetch_prefetch_ctrl.sv
// Instruction prefetch sequencer: issues sequential fetches while FIFO credit allows,
// pushes {pc, instr} entries and flushes/discards on branch redirect.
module ifetch_prefetch_ctrl
   import ifetch_prefetch_ctrl_pkg::*;
#(
   parameter int DEPTH_LOG2 = 3,
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int MAX_OUTST  = 2
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           en,
   input  logic [ADDR_WIDTH-1:0]          boot_pc,
   input  logic                           redirect,
   input  logic [ADDR_WIDTH-1:0]          redirect_pc,
   output logic                           mem_req,
   output logic [ADDR_WIDTH-1:0]          mem_addr,
   input  logic                           mem_gnt,
   input  logic                           mem_rvalid,
   input  logic [DATA_WIDTH-1:0]          mem_rdata,
   output logic                           fifo_wr_en,
   output logic [ADDR_WIDTH+DATA_WIDTH-1:0] fifo_din,
   output logic                           fifo_flush,
   input  logic                           cons_pop
);

   localparam logic [ADDR_WIDTH-1:0] PC_STEP = ADDR_WIDTH'(PC_INC);

   ipf_state_e            state, state_nxt;
   logic [ADDR_WIDTH-1:0] pc, rsp_pc, pend_addr;
   logic                  req_pend, redirect_act, gnt_fire, held;
   logic                  push, credit, credit_nxt, drained;

   assign redirect_act = redirect && (state != IDLE);
   assign gnt_fire     = mem_req && mem_gnt;
   assign held         = mem_req && !mem_gnt;
   // A request left hanging keeps its address even after pc is redirected.
   assign mem_addr     = req_pend ? pend_addr : pc;
   assign fifo_wr_en   = push;
   assign fifo_din     = push ? {rsp_pc, mem_rdata} : '0;

   ipf_credit_cnt #(
      .DEPTH_LOG2 (DEPTH_LOG2),
      .MAX_OUTST  (MAX_OUTST)
   ) u_credit (
      .clk        (clk),
      .rst        (rst),
      .gnt_fire   (gnt_fire),
      .rvalid     (mem_rvalid),
      .pop        (cons_pop),
      .redirect   (redirect_act),
      .held       (held),
      .flush      (fifo_flush),
      .push       (push),
      .credit     (credit),
      .credit_nxt (credit_nxt),
      .drained    (drained)
   );

   always_comb begin
      mem_req   = 1'b0;
      state_nxt = state;
      case (state)
         IDLE: begin
            if (en) state_nxt = FETCH;
         end
         FETCH: begin
            mem_req = req_pend || (en && credit);
            if (gnt_fire)
               state_nxt = credit_nxt ? FETCH : WAIT;
            else if (!mem_req)
               state_nxt = en ? WAIT : IDLE;
         end
         WAIT: begin
            if (credit) state_nxt = FETCH;
         end
         DRAIN: begin
            mem_req = req_pend;
            if (drained) state_nxt = FETCH;
         end
         default: state_nxt = IDLE;
      endcase
      if (redirect_act) state_nxt = DRAIN;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         pc         <= boot_pc;
         rsp_pc     <= boot_pc;
         pend_addr  <= '0;
         req_pend   <= 1'b0;
         fifo_flush <= 1'b0;
      end else begin
         state      <= state_nxt;
         req_pend   <= held;
         pend_addr  <= mem_addr;
         fifo_flush <= redirect_act;
         if (redirect) begin
            pc     <= redirect_pc;
            rsp_pc <= redirect_pc;
         end else begin
            // A grant in DRAIN belongs to the abandoned stream and must not advance pc.
            if ((state == FETCH) && gnt_fire) pc <= pc + PC_STEP;
            if (push) rsp_pc <= rsp_pc + PC_STEP;
         end
      end
   end

endmodule

// File: doc/ifetch_prefetch_ctrl.md
Name: ifetch_prefetch_ctrl

Overview:
- Prefetch sequencer for the instruction buffer FIFO between the instruction-memory bus and decode.
- Issues sequential fetch requests on a req/gnt/rvalid bus, only when the FIFO has free space for them.
- Pushes {pc, instr} entries into the FIFO.
- Handles branch redirects by flushing the FIFO and discarding in-flight responses before fetching from the new PC.

Parameters:
- DEPTH_LOG2, 3, log2 of FIFO entry count (8 entries); matches the FIFO's depth exponent.
- ADDR_WIDTH, 32, PC/bus address width.
- DATA_WIDTH, 32, instruction width.
- MAX_OUTST, 2, maximum granted-but-unanswered requests (1..3).

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- en  in  1  level; fetching allowed while high
- boot_pc  in  ADDR_WIDTH  PC loaded at reset release
- redirect  in  1  one-cycle pulse: branch/exception target valid
- redirect_pc  in  ADDR_WIDTH  new fetch PC
- mem_req  out  1  fetch request
- mem_addr  out  ADDR_WIDTH  fetch address
- mem_gnt  in  1  request accepted this cycle
- mem_rvalid  in  1  response data valid (in request order)
- mem_rdata  in  DATA_WIDTH  instruction
- fifo_wr_en  out  1  push to FIFO
- fifo_din  out  ADDR_WIDTH+DATA_WIDTH  {pc, instr}, pc in MSBs
- fifo_flush  out  1  one-cycle FIFO clear
- cons_pop  in  1  consumer pop (rd_en && !empty at FIFO)

Behaviour:
- Reset (async): state=IDLE; mem_req=0, mem_addr=boot_pc, fifo_wr_en=0, fifo_flush=0, fifo_din=0. Internal: pc=boot_pc, rsp_pc=boot_pc, occ=0, outst=0, discard=0.
- Credit rule: issue allowed iff occ+outst < 2**DEPTH_LOG2 and outst < MAX_OUTST. occ is width DEPTH_LOG2+1 and never exceeds 2**DEPTH_LOG2; the FIFO is never written while full.
- States:
  - IDLE: moves to FETCH when en=1.
  - FETCH: mem_req=1, mem_addr=pc.
    - Req/addr are held stable until mem_gnt; req is never withdrawn.
    - On gnt: pc+=4, outst++. Stay in FETCH if credit remains next cycle, else go to WAIT.
    - en=0 with no req pending goes to IDLE.
  - WAIT: mem_req=0; returns to FETCH when credit is available.
  - DRAIN: mem_req=0 unless an un-granted pre-redirect request is still held; goes to FETCH when discard==0 and outst==0.
- Response, discard==0: fifo_wr_en=1 the same cycle, combinational from mem_rvalid. fifo_din={rsp_pc, mem_rdata}; rsp_pc+=4; outst--; occ++.
- Response, discard>0: no push; discard--, outst--.
- occ-- on cons_pop. Pop and push in the same cycle leave occ unchanged.
- Redirect (any state except IDLE; ignored in IDLE apart from the PC load):
  - fifo_flush=1 next cycle for exactly one cycle.
  - occ<=0; pc<=rsp_pc<=redirect_pc.
  - discard<=outst, plus 1 for a held request (it is counted when granted); go to DRAIN.
- Same-cycle events with redirect:
  - mem_rvalid: that response is discarded, not pushed.
  - mem_gnt: the granted request joins the discard count.
  - cons_pop: ignored.
  - Another redirect in DRAIN: reload pc/rsp_pc; discard keeps counting.
- Arithmetic: pc wraps modulo 2**ADDR_WIDTH. outst never underflows; rvalid with outst==0 is a bus protocol error (bench assertion).
- en deassert: no new requests. In-flight responses still complete and push.

Decomposition:
- Shared package/defines (top_defines.v): state encodings IDLE=0, FETCH=1, WAIT=2, DRAIN=3; the PC increment constant 4; the FIFO entry layout (PC field high, instr low).
- One sub-module is natural: ipf_credit_cnt, holding the occ/outst/discard counters and the credit-available output. The FSM and PC logic stay in the top.

Test Plan:
- Reset release, boot_pc=0x8000_0000, en=1, gnt immediate, rvalid 1 cycle later, no pops -> exactly 8 requests 0x8000_0000..0x8000_001C; req low after the 8th; fifo_din PCs in order.
- Full buffer, then one cons_pop -> exactly one new request at 0x8000_0020, then back to WAIT.
- 2 outstanding, redirect to 0x8000_1000 -> fifo_flush for one cycle; the next 2 rvalids are not pushed; first push is {0x8000_1000, data}.
- mem_req held with gnt delayed 5 cycles, redirect in cycle 2 -> mem_addr stable through gnt; that response is discarded; then fetch resumes at redirect_pc.
- Redirect coincident with rvalid and cons_pop -> no push that cycle; occ=0 after flush; no credit error.
- Assert rst mid-DRAIN -> all outputs reach reset values immediately (asynchronous), without waiting for a clock edge.
